// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one single-ported memory; data has priority, fetch has starvation relief.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata,
  output logic          bus_err
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023)
  begin : gen_param_check
    $error("mem_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StWaitI, StWaitD} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  state_e        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          win_i, win_d;
  logic          timeout;
  logic [DW-1:0] rsp_data;

`ifdef ARB_TIMEOUT_EN
  localparam logic [9:0]    TimeoutLim = 10'(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] ErrData    = DW'(32'hDEAD_BEEF);

  logic [9:0] wait_q, wait_d;

  // Counter sits at zero in IDLE so it starts fresh on every WAIT entry.
  assign timeout  = (state_q != StIdle) && !m_rvalid && (wait_q == TimeoutLim);
  assign rsp_data = m_rvalid ? m_rdata : ErrData;
  assign wait_d   = (state_q == StIdle) ? 10'd0 : wait_q + 10'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= 10'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout  = 1'b0;
  assign rsp_data = m_rdata;
`endif

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    bus_err  = 1'b0;

    win_i = i_req && (!d_req || (starve_q == StarveMax));
    win_d = d_req && !win_i;

    unique case (state_q)
      StIdle: begin
        m_req = win_i || win_d;
        if (win_i) begin
          m_addr = i_addr;
          i_gnt  = m_gnt;
        end else if (win_d) begin
          m_addr  = d_addr;
          m_we    = d_we;
          m_wdata = d_wdata;
          d_gnt   = m_gnt;
        end
        if (i_gnt) begin
          starve_d = 4'd0;
          state_d  = StWaitI;
        end else begin
          if (!i_req) begin
            starve_d = 4'd0;
          end else if (d_gnt && (starve_q != StarveMax)) begin
            starve_d = starve_q + 4'd1;
          end
          if (d_gnt) begin
            state_d = StWaitD;
          end
        end
      end
      StWaitI: begin
        if (m_rvalid || timeout) begin
          i_rvalid = 1'b1;
          i_rdata  = rsp_data;
          bus_err  = timeout;
          state_d  = StIdle;
        end
      end
      StWaitD: begin
        if (m_rvalid || timeout) begin
          d_rvalid = 1'b1;
          d_rdata  = rsp_data;
          bus_err  = timeout;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are held quiet while reset is asserted, even if requests are present.
    if (rst) begin
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
      i_rdata  = '0;
      d_rdata  = '0;
      m_req    = 1'b0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      bus_err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SL = 4;
  localparam int unsigned TO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_gnt = 1'b0;
  logic          m_rvalid = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          bus_err;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
  endtask

  // Called in a grant cycle: answer the transaction next cycle, then leave an idle cycle.
  task automatic drain();
    step();
    clear_in();
    m_rvalid = 1'b1;
    step();
    m_rvalid = 1'b0;
  endtask

  // Reference model: owner 0=none, 1=fetch, 2=data. Evaluated mid-cycle with stable inputs.
  initial begin : model
    int owner, starve, wcnt, win;
    logic e_ig, e_dg, e_iv, e_dv, e_mreq, e_mwe, e_err, done, to;
    logic [31:0] e_ird, e_drd, e_maddr, e_mwd, rd;
    owner = 0; starve = 0; wcnt = 0;
    forever begin
      @(negedge clk);
      e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_mreq = 0; e_mwe = 0; e_err = 0;
      e_ird = 0; e_drd = 0; e_maddr = 0; e_mwd = 0;
      if (rst) begin
        owner = 0; starve = 0; wcnt = 0;
      end else if (owner == 0) begin
        if (i_req && d_req) win = (starve == SL) ? 1 : 2;
        else if (d_req) win = 2;
        else if (i_req) win = 1;
        else win = 0;
        e_mreq  = (win != 0);
        e_maddr = (win == 1) ? i_addr : (win == 2) ? d_addr : 32'd0;
        e_mwe   = (win == 2) && d_we;
        e_mwd   = (win == 2) ? d_wdata : 32'd0;
        e_ig    = (win == 1) && m_gnt;
        e_dg    = (win == 2) && m_gnt;
        wcnt = 0;
        if (e_ig) begin
          starve = 0; owner = 1;
        end else begin
          if (!i_req) starve = 0;
          else if (e_dg && starve < SL) starve = starve + 1;
          if (e_dg) owner = 2;
        end
      end else begin
        to   = ToEn && !m_rvalid && (wcnt == TO);
        done = m_rvalid || to;
        rd   = m_rvalid ? m_rdata : 32'hDEAD_BEEF;
        if (done) begin
          if (owner == 1) begin e_iv = 1; e_ird = rd; end
          else begin e_dv = 1; e_drd = rd; end
          e_err = to;
          owner = 0;
        end else begin
          wcnt = wcnt + 1;
        end
      end
      chk("m_req", 32'(m_req), 32'(e_mreq));
      chk("m_we", 32'(m_we), 32'(e_mwe));
      chk("m_addr", m_addr, e_maddr);
      chk("m_wdata", m_wdata, e_mwd);
      chk("i_gnt", 32'(i_gnt), 32'(e_ig));
      chk("d_gnt", 32'(d_gnt), 32'(e_dg));
      chk("i_rvalid", 32'(i_rvalid), 32'(e_iv));
      chk("d_rvalid", 32'(d_rvalid), 32'(e_dv));
      chk("i_rdata", i_rdata, e_ird);
      chk("d_rdata", d_rdata, e_drd);
      chk("bus_err", 32'(bus_err), 32'(e_err));
    end
  end

  initial begin : stim
    logic ig, dg;

    // Reset with requests present: everything quiet.
    step();
    d_req = 1'b1; i_req = 1'b1; m_gnt = 1'b1; d_addr = 32'h44;
    #2;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    step();
    rst = 1'b0;
    clear_in();

    // Fetch only.
    i_req = 1'b1; i_addr = 32'h100; m_gnt = 1'b1;
    #2;
    chk("f_i_gnt", 32'(i_gnt), 32'd1);
    chk("f_m_addr", m_addr, 32'h100);
    chk("f_m_we", 32'(m_we), 32'd0);
    step();
    i_req = 1'b0; m_gnt = 1'b0;
    #2;
    chk("f_wait_m_req", 32'(m_req), 32'd0);
    step();
    m_rvalid = 1'b1; m_rdata = 32'h0050_0093; i_req = 1'b1; m_gnt = 1'b1;
    #2;
    chk("f_i_rvalid", 32'(i_rvalid), 32'd1);
    chk("f_i_rdata", i_rdata, 32'h0050_0093);
    chk("f_turn_gnt", 32'(i_gnt), 32'd0);
    step();
    m_rvalid = 1'b0;
    #2;
    chk("f_next_gnt", 32'(i_gnt), 32'd1);
    drain();

    // Contention: data first, fetch after the data response.
    i_req = 1'b1; i_addr = 32'h104; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; m_gnt = 1'b1;
    #2;
    chk("c_d_gnt", 32'(d_gnt), 32'd1);
    chk("c_i_gnt", 32'(i_gnt), 32'd0);
    chk("c_m_addr", m_addr, 32'h2000);
    step();
    d_req = 1'b0;
    step();
    m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
    #2;
    chk("c_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("c_i_gnt_wait", 32'(i_gnt), 32'd0);
    step();
    m_rvalid = 1'b0;
    #2;
    chk("c_i_gnt_late", 32'(i_gnt), 32'd1);
    chk("c_i_addr", m_addr, 32'h104);
    drain();

    // Starvation relief: four data grants, then fetch, then data again.
    for (int k = 0; k < 6; k++) begin
      i_req = 1'b1; d_req = 1'b1; m_gnt = 1'b1; m_rvalid = 1'b0;
      #2;
      chk($sformatf("s_d_gnt%0d", k), 32'(d_gnt), 32'(k != 4));
      chk($sformatf("s_i_gnt%0d", k), 32'(i_gnt), 32'(k == 4));
      step();
      m_gnt = 1'b0; m_rvalid = 1'b1;
      step();
    end
    clear_in();
    step();

    // Store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hA5A5_A5A5; m_gnt = 1'b1;
    #2;
    chk("st_m_we", 32'(m_we), 32'd1);
    chk("st_m_wdata", m_wdata, 32'hA5A5_A5A5);
    chk("st_d_gnt", 32'(d_gnt), 32'd1);
    step();
    clear_in();
    m_rvalid = 1'b1; m_rdata = 32'h0000_0001;
    #2;
    chk("st_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("st_i_rvalid", 32'(i_rvalid), 32'd0);
    step();
    m_rvalid = 1'b0;

    // Reset in WAIT_D, stale response afterwards.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; m_gnt = 1'b1;
    step();
    clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    #2;
    chk("r_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("r_d_rdata", d_rdata, 32'd0);
    chk("r_m_req", 32'(m_req), 32'd0);
    step();
    m_rvalid = 1'b0; i_req = 1'b1; i_addr = 32'h200; m_gnt = 1'b1;
    #2;
    chk("r_idle_gnt", 32'(i_gnt), 32'd1);
    drain();

    // Response watchdog.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; m_gnt = 1'b1;
    step();
    clear_in();
    for (int j = 0; j < TO; j++) begin
      #2;
      chk($sformatf("t_wait_rv%0d", j), 32'(d_rvalid), 32'd0);
      chk($sformatf("t_wait_err%0d", j), 32'(bus_err), 32'd0);
      step();
    end
    #2;
`ifdef ARB_TIMEOUT_EN
    chk("t_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("t_d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("t_bus_err", 32'(bus_err), 32'd1);
    step();
    #2;
    chk("t_err_pulse", 32'(bus_err), 32'd0);
    chk("t_rv_after", 32'(d_rvalid), 32'd0);
`else
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t_hold_rv%0d", j), 32'(d_rvalid), 32'd0);
      chk($sformatf("t_hold_err%0d", j), 32'(bus_err), 32'd0);
      step();
      #2;
    end
    step();
    m_rvalid = 1'b1;
    step();
    m_rvalid = 1'b0;
`endif
    step();

    // Randomized traffic obeying the requester hold rule.
    ig = 1'b0; dg = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (i_req && !ig) begin
        if ($urandom_range(9) == 0) i_req = 1'b0;
      end else begin
        i_req  = 1'($urandom_range(1));
        i_addr = $urandom;
      end
      if (d_req && !dg) begin
        if ($urandom_range(9) == 0) d_req = 1'b0;
      end else begin
        d_req   = 1'($urandom_range(1));
        d_we    = 1'($urandom_range(1));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      m_gnt    = ($urandom_range(2) != 0);
      m_rvalid = ($urandom_range(2) == 0);
      m_rdata  = $urandom;
      rst      = ($urandom_range(99) == 0);
      #2;
      ig = i_gnt;
      dg = d_gnt;
      step();
    end
    rst = 1'b0;
    clear_in();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
